// File: rtl/por_pkg.sv
// Shared types and helpers for the power-on-reset sequencer.
`timescale 1ns/1ps
package por_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR = 2'b01;
    localparam cause_t CAUSE_SW  = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser.
`timescale 1ns/1ps
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift ones in after release; clear the whole chain the instant reset asserts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on-reset consumer: debounces the POR release, then frees the reset
// domains one by one; also services a software reset request.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  HOLD    | POR seen; waiting HOLD_CYCLES after synchronised release
//  RELEASE | freeing domains in index order, STAGE_GAP cycles apart
//  RUN     | all domains free, done flag high, SW requests accepted
//  SW_HOLD | SW reset: all domains low for SW_PULSE cycles
`timescale 1ns/1ps
module por_reset_sequencer
    import por_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 3,
    parameter int STAGE_GAP   = 4,
    parameter int SW_PULSE    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic                   rst_done_o,
    output logic [1:0]             rst_cause_o
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (NUM_DOMAINS < 1) begin : g_chk_dom
        $error("NUM_DOMAINS must be at least 1");
    end
    if (STAGE_GAP < 1) begin : g_chk_gap
        $error("STAGE_GAP must be at least 1");
    end
    if (SW_PULSE < 1) begin : g_chk_sw
        $error("SW_PULSE must be at least 1");
    end

    localparam int CNT_MAX = max3(HOLD_CYCLES, STAGE_GAP, SW_PULSE);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SW_LAST   = CW'(SW_PULSE - 1);
    localparam logic [IW-1:0] IDX_END   = IW'(NUM_DOMAINS);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [IW-1:0]          r_idx, w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_rst_no, w_rst_no_nxt;
    logic                   r_done, w_done_nxt;
    cause_t                 r_cause, w_cause_nxt;
    logic                   r_sw_req_q;
    logic                   w_rst_sync;
    logic                   w_sw_trig;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .o_rst_sync (w_rst_sync)
    );

    // Only a fresh rising edge seen while running counts; the history flop
    // tracks the input in every state so edges elsewhere are simply lost.
    assign w_sw_trig = (r_state == RUN) && sw_rst_req_i && !r_sw_req_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_no   <= '0;
            r_done     <= 1'b0;
            r_cause    <= CAUSE_POR;
            r_sw_req_q <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_no   <= w_rst_no_nxt;
            r_done     <= w_done_nxt;
            r_cause    <= w_cause_nxt;
            r_sw_req_q <= sw_rst_req_i;
        end
    end

    // Next state, cycle counter and domain index.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            HOLD: begin
                if (w_rst_sync) begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nxt = RELEASE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = IDX_ONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (r_idx == IDX_END) begin
                    w_state_nxt = RUN;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_sw_trig) begin
                    w_state_nxt = SW_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            SW_HOLD: begin
                if (r_cnt == SW_LAST) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = HOLD;
            end
        endcase
    end

    // Next values of the reset lines, done flag and cause.
    always_comb begin
        w_rst_no_nxt = r_rst_no;
        w_done_nxt   = r_done;
        w_cause_nxt  = r_cause;
        case (r_state)
            HOLD: begin
                if (w_rst_sync && (r_cnt == HOLD_LAST)) begin
                    w_rst_no_nxt[0] = 1'b1;
                end
            end
            RELEASE: begin
                if (r_idx == IDX_END) begin
                    w_done_nxt = 1'b1;
                end else if (r_cnt == GAP_LAST) begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (r_idx == IW'(k)) begin
                            w_rst_no_nxt[k] = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (w_sw_trig) begin
                    w_rst_no_nxt = '0;
                    w_done_nxt   = 1'b0;
                    w_cause_nxt  = CAUSE_SW;
                end
            end
            SW_HOLD: begin
                if (r_cnt == SW_LAST) begin
                    w_rst_no_nxt[0] = 1'b1;
                end
            end
            default: begin
                w_rst_no_nxt = '0;
            end
        endcase
    end

    assign rst_no      = r_rst_no;
    assign rst_done_o  = r_done;
    assign rst_cause_o = r_cause;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer: expected snapshots are queued when
// stimulus is applied and popped against the DUT after each clock edge.
`timescale 1ns/1ps
module tb_por_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n0 = 1'b1;
    logic       rst_n1 = 1'b1;
    logic       sw0 = 1'b0;
    logic       sw1 = 1'b0;
    logic [2:0] rst_no0;
    logic       done0;
    logic [1:0] cause0;
    logic [0:0] rst_no1;
    logic       done1;
    logic [1:0] cause1;

    always #5 clk = ~clk;

    por_reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_DOMAINS(3), .STAGE_GAP(4), .SW_PULSE(8)
    ) u_dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n0),
        .sw_rst_req_i (sw0),
        .rst_no       (rst_no0),
        .rst_done_o   (done0),
        .rst_cause_o  (cause0)
    );

    por_reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGE_GAP(1), .SW_PULSE(8)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_n1),
        .sw_rst_req_i (sw1),
        .rst_no       (rst_no1),
        .rst_done_o   (done1),
        .rst_cause_o  (cause1)
    );

    typedef struct {
        int          sel;
        int          edge_n;
        logic [5:0]  exp;
        logic [63:0] tag;
    } item_t;

    item_t q[$];
    int    edge_cnt    = 0;
    int    vectors     = 0;
    int    miscompares = 0;

    localparam logic [1:0] C_POR = 2'b01;
    localparam logic [1:0] C_SW  = 2'b10;

    // Reference timing: domain k free from edge base+k*gap, done one edge after the last.
    function automatic logic [5:0] exp_vec(input int sel, input int base, input int n,
                                           input logic [1:0] cause);
        int         nd;
        int         gap;
        logic [2:0] r;
        logic       d;
        nd  = (sel != 0) ? 1 : 3;
        gap = (sel != 0) ? 1 : 4;
        r   = '0;
        for (int k = 0; k < nd; k++) begin
            r[k] = (n >= base + k * gap);
        end
        d = (n >= base + (nd - 1) * gap + 1);
        return {r, d, cause};
    endfunction

    task automatic push_seq(input logic [63:0] tag, input int sel, input int base,
                            input int from, input int to, input logic [1:0] cause);
        for (int n = from; n <= to; n++) begin
            q.push_back('{sel: sel, edge_n: n, exp: exp_vec(sel, base, n, cause), tag: tag});
        end
    endtask

    task automatic push_one(input logic [63:0] tag, input int sel, input logic [5:0] exp);
        q.push_back('{sel: sel, edge_n: edge_cnt, exp: exp, tag: tag});
    endtask

    task automatic check_due();
        item_t      it;
        logic [5:0] obs;
        while (q.size() > 0 && q[0].edge_n <= edge_cnt) begin
            it  = q.pop_front();
            obs = (it.sel != 0) ? {2'b00, rst_no1, done1, cause1} : {rst_no0, done0, cause0};
            vectors++;
            assert (obs === it.exp)
            else begin
                miscompares++;
                $error("FAIL %0s edge %0d: observed rst_no/done/cause=%b expected %b",
                       it.tag, it.edge_n, obs, it.exp);
            end
        end
    endtask

    // One edge per iteration; compare just after the edge, return at the negedge.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_cnt++;
            check_due();
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state of both instances.
        #2;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        cycles(3);
        push_one("rst0", 0, {3'b000, 1'b0, C_POR});
        push_one("rst1", 1, {3'b000, 1'b0, C_POR});
        check_due();

        // Clean POR release.
        rst_n0   = 1'b1;
        edge_cnt = 0;
        push_seq("por", 0, 18, 1, 30, C_POR);
        cycles(30);

        // Restart, then glitch POR low for 1 ns just after edge 20.
        rst_n0 = 1'b0;
        cycles(2);
        rst_n0   = 1'b1;
        edge_cnt = 0;
        push_seq("pre_gl", 0, 18, 1, 19, C_POR);
        cycles(19);
        @(posedge clk);
        #1;
        edge_cnt++;
        push_one("pre_gl", 0, exp_vec(0, 18, 20, C_POR));
        check_due();
        #1;
        rst_n0 = 1'b0;
        #1;
        push_one("glitch", 0, {3'b000, 1'b0, C_POR});
        check_due();
        rst_n0   = 1'b1;
        edge_cnt = 0;
        push_seq("post_gl", 0, 18, 1, 28, C_POR);
        @(negedge clk);
        cycles(28);

        // SW reset, request held high afterwards: exactly one trigger.
        sw0      = 1'b1;
        edge_cnt = 0;
        push_seq("sw", 0, 9, 1, 25, C_SW);
        cycles(25);

        // Extra rising edges during SW_HOLD/RELEASE are ignored.
        sw0 = 1'b0;
        cycles(2);
        sw0      = 1'b1;
        edge_cnt = 0;
        push_seq("sw_tog", 0, 9, 1, 24, C_SW);
        for (int n = 1; n <= 24; n++) begin
            cycles(1);
            sw0 = (n + 1 <= 15) ? ((n + 1) % 3 != 0) : 1'b0;
        end

        // Request high through POR and release: no SW reset.
        sw0    = 1'b1;
        rst_n0 = 1'b0;
        cycles(2);
        rst_n0   = 1'b1;
        edge_cnt = 0;
        push_seq("held", 0, 18, 1, 32, C_POR);
        cycles(32);

        // A later 0->1 in RUN triggers one SW reset.
        sw0 = 1'b0;
        cycles(2);
        sw0      = 1'b1;
        edge_cnt = 0;
        push_seq("rearm", 0, 9, 1, 22, C_SW);
        cycles(22);

        // POR overrides SW cause asynchronously.
        rst_n0 = 1'b0;
        #1;
        push_one("por_ovr", 0, {3'b000, 1'b0, C_POR});
        check_due();

        // Minimal-parameter instance.
        @(negedge clk);
        rst_n1   = 1'b1;
        edge_cnt = 0;
        push_seq("sweep", 1, 3, 1, 6, C_POR);
        cycles(6);

        vectors++;
        assert (q.size() == 0)
        else begin
            miscompares++;
            $error("FAIL queue_drain: observed %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
